// File: rtl/hazard_pkg.sv
// Shared constants and types for the forwarding / hazard unit and its helpers.
package hazard_pkg;

    localparam int AW_DEF       = 5;
    localparam int LINK_REG_DEF = 31;

    // Forward-select encoding: 0 reads the register file, k+1 takes producer k.
    localparam int FWD_RF = 0;

    function automatic int fwd_p(input int k);
        return k + 1;
    endfunction

    typedef struct packed {
        logic              wen;
        logic [AW_DEF-1:0] rd;
        logic              link;
        logic              load;
    } prod_t;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Bus between the ID/EX pipeline control (master) and the hazard unit (slave).
interface fwd_hazard_unit_if #(
    parameter int NUM_SRC = 2,
    parameter int NUM_FWD = 2,
    parameter int AW      = 5,
    parameter int CNT_W   = 16,
    parameter int SW      = $clog2(NUM_FWD + 1)
);
    logic [NUM_FWD-1:0]    prod_wen;
    logic [NUM_FWD*AW-1:0] prod_rd;
    logic [NUM_FWD-1:0]    prod_link;
    logic [NUM_FWD-1:0]    prod_load;
    logic                  ex_wen;
    logic [AW-1:0]         ex_rd;
    logic                  ex_load;
    logic [NUM_SRC*AW-1:0] ex_src_reg;
    logic [NUM_SRC*SW-1:0] ex_fwd_sel;
    logic [NUM_SRC*AW-1:0] id_src_reg;
    logic [NUM_SRC-1:0]    id_src_used;
    logic                  id_branch;
    logic [NUM_SRC*SW-1:0] id_fwd_sel;
    logic                  id_mdu_start;
    logic [AW-1:0]         id_mdu_rd;
    logic                  flush;
    logic                  stall;
    logic                  mdu_busy;
    logic                  mdu_done;
    logic [AW-1:0]         mdu_done_rd;
    logic [CNT_W-1:0]      stall_cnt;

    modport master (
        output prod_wen, prod_rd, prod_link, prod_load, ex_wen, ex_rd, ex_load,
               ex_src_reg, id_src_reg, id_src_used, id_branch, id_mdu_start,
               id_mdu_rd, flush,
        input  ex_fwd_sel, id_fwd_sel, stall, mdu_busy, mdu_done, mdu_done_rd,
               stall_cnt
    );

    modport slave (
        input  prod_wen, prod_rd, prod_link, prod_load, ex_wen, ex_rd, ex_load,
               ex_src_reg, id_src_reg, id_src_used, id_branch, id_mdu_start,
               id_mdu_rd, flush,
        output ex_fwd_sel, id_fwd_sel, stall, mdu_busy, mdu_done, mdu_done_rd,
               stall_cnt
    );

endinterface

// File: rtl/fwd_match.sv
// Priority match of one source register against all producer stages;
// the youngest (lowest index) unskipped match wins.
module fwd_match
    import hazard_pkg::*;
#(
    parameter int NUM_FWD  = 2,
    parameter int AW       = AW_DEF,
    parameter int LINK_REG = LINK_REG_DEF,
    parameter int SW       = $clog2(NUM_FWD + 1)
) (
    input  logic [AW-1:0]         src,
    input  logic [NUM_FWD-1:0]    wen,
    input  logic [NUM_FWD*AW-1:0] rd,
    input  logic [NUM_FWD-1:0]    link,
    input  logic [NUM_FWD-1:0]    skip,
    output logic [SW-1:0]         sel
);

    localparam logic [AW-1:0] LINK = AW'(LINK_REG);

    logic [NUM_FWD-1:0] hit;

    for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_hit
        assign hit[gi] = !skip[gi] && wen[gi] &&
                         ((rd[gi*AW +: AW] == src && src != '0) ||
                          (link[gi] && src == LINK));
    end

    always_comb begin
        sel = SW'(FWD_RF);
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (hit[k]) sel = SW'(fwd_p(k));
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand-forward selects for EX and ID branch compares, load/branch/MDU stall
// detection, a single-entry MDU scoreboard and a saturating stall counter.
module fwd_hazard_unit
    import hazard_pkg::*;
#(
    parameter int NUM_SRC  = 2,
    parameter int NUM_FWD  = 2,
    parameter int AW       = AW_DEF,
    parameter int LINK_REG = LINK_REG_DEF,
    parameter int MDU_LAT  = 4,
    parameter int CNT_W    = 16,
    parameter int SW       = $clog2(NUM_FWD + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    fwd_hazard_unit_if.slave bus
);

    localparam int CW = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
    localparam logic [AW-1:0] LINK = AW'(LINK_REG);

    logic             busy_q, busy_d;
    logic [AW-1:0]    busy_rd_q, busy_rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [NUM_SRC-1:0]         src_haz;
    logic                       stall;
    logic [NUM_FWD-1:0]         ex_skip, id_skip;
    logic [NUM_SRC-1:0][SW-1:0] ex_sel_all, id_sel_all;

    assign ex_skip = '0;
    // A load in EX/MEM cannot feed an ID compare yet, so it stalls instead.
    assign id_skip = NUM_FWD'(bus.prod_load[0]);

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        logic [AW-1:0] ex_src, id_src;
        logic [SW-1:0] id_sel;
        logic          p0_hit;

        assign ex_src = bus.ex_src_reg[gi*AW +: AW];
        assign id_src = bus.id_src_reg[gi*AW +: AW];

        fwd_match #(.NUM_FWD(NUM_FWD), .AW(AW), .LINK_REG(LINK_REG), .SW(SW)) u_ex (
            .src(ex_src), .wen(bus.prod_wen), .rd(bus.prod_rd),
            .link(bus.prod_link), .skip(ex_skip), .sel(ex_sel_all[gi])
        );

        fwd_match #(.NUM_FWD(NUM_FWD), .AW(AW), .LINK_REG(LINK_REG), .SW(SW)) u_id (
            .src(id_src), .wen(bus.prod_wen), .rd(bus.prod_rd),
            .link(bus.prod_link), .skip(id_skip), .sel(id_sel)
        );

        assign id_sel_all[gi] = bus.id_branch ? id_sel : SW'(FWD_RF);

        assign p0_hit = bus.prod_wen[0] &&
                        ((bus.prod_rd[AW-1:0] == id_src && id_src != '0) ||
                         (bus.prod_link[0] && id_src == LINK));

        assign src_haz[gi] = bus.id_src_used[gi] && (
            (bus.ex_load && bus.ex_wen && bus.ex_rd != '0 && bus.ex_rd == id_src) ||
            (bus.id_branch && bus.ex_wen && bus.ex_rd != '0 && bus.ex_rd == id_src) ||
            (bus.id_branch && bus.prod_load[0] && p0_hit) ||
            (busy_q && busy_rd_q != '0 && busy_rd_q == id_src));
    end

    assign stall = !bus.flush && ((|src_haz) || (bus.id_mdu_start && busy_q));

    always_comb begin
        busy_d    = busy_q;
        busy_rd_d = busy_rd_q;
        cnt_d     = cnt_q;
        if (busy_q) begin
            if (cnt_q != '0) cnt_d  = cnt_q - 1'b1;
            else             busy_d = 1'b0;
        end
        // A busy MDU always stalls a new issue, so this never overlaps completion.
        if (bus.id_mdu_start && !stall && !bus.flush) begin
            busy_d    = 1'b1;
            busy_rd_d = bus.id_mdu_rd;
            cnt_d     = CW'(MDU_LAT - 1);
        end
        stall_cnt_d = (stall && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= 1'b0;
            busy_rd_q   <= '0;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            busy_q      <= busy_d;
            busy_rd_q   <= busy_rd_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.ex_fwd_sel  = ex_sel_all;
    assign bus.id_fwd_sel  = id_sel_all;
    assign bus.stall       = stall;
    assign bus.mdu_busy    = busy_q;
    assign bus.mdu_done    = busy_q && (cnt_q == '0);
    assign bus.mdu_done_rd = busy_rd_q;
    assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed and randomized checks of fwd_hazard_unit against a cycle-timestamp reference model.
module tb_fwd_hazard_unit;

    localparam int NUM_SRC  = 2;
    localparam int NUM_FWD  = 2;
    localparam int AW       = 5;
    localparam int LINK_REG = 31;
    localparam int MDU_LAT  = 4;
    localparam int CNT_W    = 16;
    localparam int SW       = $clog2(NUM_FWD + 1);

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD), .AW(AW), .CNT_W(CNT_W), .SW(SW)) bus();

    fwd_hazard_unit #(
        .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD), .AW(AW), .LINK_REG(LINK_REG),
        .MDU_LAT(MDU_LAT), .CNT_W(CNT_W), .SW(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.prod_wen = '0; bus.prod_rd = '0; bus.prod_link = '0; bus.prod_load = '0;
        bus.ex_wen = 1'b0; bus.ex_rd = '0; bus.ex_load = 1'b0; bus.ex_src_reg = '0;
        bus.id_src_reg = '0; bus.id_src_used = '0; bus.id_branch = 1'b0;
        bus.id_mdu_start = 1'b0; bus.id_mdu_rd = '0; bus.flush = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic set_prod(input int k, input bit wen, input int rd, input bit link, input bit load);
        bus.prod_wen[k]          = wen;
        bus.prod_rd[k*AW +: AW]  = AW'(rd);
        bus.prod_link[k]         = link;
        bus.prod_load[k]         = load;
    endtask

    task automatic set_ex_src(input int r, input int rg);
        bus.ex_src_reg[r*AW +: AW] = AW'(rg);
    endtask

    task automatic set_id_src(input int r, input int rg, input bit used);
        bus.id_src_reg[r*AW +: AW] = AW'(rg);
        bus.id_src_used[r]         = used;
    endtask

    function automatic logic [SW-1:0] ex_sel(input int r);
        return bus.ex_fwd_sel[r*SW +: SW];
    endfunction

    function automatic logic [SW-1:0] id_sel(input int r);
        return bus.id_fwd_sel[r*SW +: SW];
    endfunction

    // ---------------- reference model helpers ----------------
    function automatic bit m_match(input int k, input logic [AW-1:0] r);
        return bus.prod_wen[k] &&
               ((bus.prod_rd[k*AW +: AW] == r && r != 0) || (bus.prod_link[k] && r == LINK_REG));
    endfunction

    function automatic logic [AW-1:0] rnd_reg();
        if ($urandom_range(0, 9) == 0) return AW'(LINK_REG);
        return AW'($urandom_range(0, 7));
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        #1;
        n_tests++; if (bus.mdu_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", bus.mdu_busy); end
        n_tests++; if (bus.mdu_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%0b exp=0", bus.mdu_done); end
        n_tests++; if (bus.stall_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt got=%0h exp=0", bus.stall_cnt); end
        n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%0b exp=0", bus.stall); end
        set_prod(0, 1, 5, 0, 0);
        set_ex_src(0, 5);
        bus.ex_load = 1'b1; bus.ex_wen = 1'b1; bus.ex_rd = 5'd5;
        set_id_src(0, 5, 1);
        #1;
        n_tests++; if (ex_sel(0) !== 2'd1) begin n_fail++; $display("FAIL reset_comb_fwd got=%0d exp=1", ex_sel(0)); end
        n_tests++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL reset_comb_stall got=%0b exp=1", bus.stall); end
        tick();
        n_tests++; if (bus.stall_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt_hold got=%0h exp=0", bus.stall_cnt); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_ex_fwd();
        do_reset();
        set_prod(0, 1, 5, 0, 0); set_prod(1, 1, 5, 0, 0);
        set_ex_src(0, 5); set_ex_src(1, 5);
        #1;
        n_tests++; if (ex_sel(0) !== 2'd1) begin n_fail++; $display("FAIL ex_youngest got=%0d exp=1", ex_sel(0)); end
        set_prod(0, 0, 5, 0, 0);
        #1;
        n_tests++; if (ex_sel(1) !== 2'd2) begin n_fail++; $display("FAIL ex_oldest got=%0d exp=2", ex_sel(1)); end
        set_prod(0, 1, 0, 0, 0); set_prod(1, 1, 0, 0, 0); set_ex_src(0, 0);
        #1;
        n_tests++; if (ex_sel(0) !== 2'd0) begin n_fail++; $display("FAIL ex_r0 got=%0d exp=0", ex_sel(0)); end
        set_prod(0, 1, 7, 1, 0); set_prod(1, 0, 0, 0, 0); set_ex_src(1, 31);
        set_id_src(1, 31, 1);
        #1;
        n_tests++; if (ex_sel(1) !== 2'd1) begin n_fail++; $display("FAIL ex_link got=%0d exp=1", ex_sel(1)); end
        n_tests++; if (bus.id_fwd_sel !== '0) begin n_fail++; $display("FAIL id_nobranch got=%0h exp=0", bus.id_fwd_sel); end
        bus.id_branch = 1'b1;
        #1;
        n_tests++; if (id_sel(1) !== 2'd1) begin n_fail++; $display("FAIL id_link got=%0d exp=1", id_sel(1)); end
        $display("[TB] test_ex_fwd done");
    endtask

    task automatic test_load_use();
        do_reset();
        bus.ex_load = 1'b1; bus.ex_wen = 1'b1; bus.ex_rd = 5'd3;
        set_id_src(0, 3, 1);
        #1;
        n_tests++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall got=%0b exp=1", bus.stall); end
        tick();
        n_tests++; if (bus.stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_cnt got=%0d exp=1", bus.stall_cnt); end
        set_id_src(0, 3, 0);
        #1;
        n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL lu_unused got=%0b exp=0", bus.stall); end
        tick();
        n_tests++; if (bus.stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_cnt_hold got=%0d exp=1", bus.stall_cnt); end
        set_id_src(0, 3, 1);
        bus.flush = 1'b1;
        #1;
        n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL lu_flush got=%0b exp=0", bus.stall); end
        bus.flush = 1'b0; bus.ex_rd = 5'd0; set_id_src(0, 0, 1);
        #1;
        n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL lu_r0 got=%0b exp=0", bus.stall); end
        $display("[TB] test_load_use done");
    endtask

    task automatic test_branch();
        do_reset();
        bus.id_branch = 1'b1;
        set_prod(0, 1, 4, 0, 1);
        set_id_src(0, 4, 1);
        #1;
        n_tests++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL br_load_stall got=%0b exp=1", bus.stall); end
        n_tests++; if (id_sel(0) !== 2'd0) begin n_fail++; $display("FAIL br_load_skip got=%0d exp=0", id_sel(0)); end
        tick();
        set_prod(0, 0, 0, 0, 0); set_prod(1, 1, 4, 0, 1);
        #1;
        n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL br_p1_stall got=%0b exp=0", bus.stall); end
        n_tests++; if (id_sel(0) !== 2'd2) begin n_fail++; $display("FAIL br_p1_sel got=%0d exp=2", id_sel(0)); end
        bus.ex_wen = 1'b1; bus.ex_rd = 5'd6; set_id_src(1, 6, 1);
        #1;
        n_tests++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL br_ex_stall got=%0b exp=1", bus.stall); end
        bus.id_branch = 1'b0;
        #1;
        n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL br_ex_nobr got=%0b exp=0", bus.stall); end
        $display("[TB] test_branch done");
    endtask

    task automatic test_mdu();
        bit exp_busy, exp_done, exp_stall;
        do_reset();
        for (int c = 0; c <= 6; c++) begin
            if (c == 0) begin bus.id_mdu_start = 1'b1; bus.id_mdu_rd = 5'd9; set_id_src(0, 9, 1); end
            if (c == 1) bus.id_mdu_start = 1'b0;
            if (c == 2) begin bus.id_mdu_start = 1'b1; bus.id_mdu_rd = 5'd12; end
            if (c == 6) bus.id_mdu_start = 1'b0;
            #1;
            exp_busy  = (c >= 1 && c <= 4) || c >= 6;
            exp_done  = (c == 4);
            exp_stall = (c >= 1 && c <= 4);
            n_tests++; if (bus.mdu_busy !== exp_busy) begin n_fail++; $display("FAIL mdu_busy c=%0d got=%0b exp=%0b", c, bus.mdu_busy, exp_busy); end
            n_tests++; if (bus.mdu_done !== exp_done) begin n_fail++; $display("FAIL mdu_done c=%0d got=%0b exp=%0b", c, bus.mdu_done, exp_done); end
            n_tests++; if (bus.stall !== exp_stall) begin n_fail++; $display("FAIL mdu_stall c=%0d got=%0b exp=%0b", c, bus.stall, exp_stall); end
            if (c == 4) begin
                n_tests++; if (bus.mdu_done_rd !== 5'd9) begin n_fail++; $display("FAIL mdu_done_rd got=%0d exp=9", bus.mdu_done_rd); end
            end
            if (c == 6) begin
                n_tests++; if (bus.mdu_done_rd !== 5'd12) begin n_fail++; $display("FAIL mdu_second_rd got=%0d exp=12", bus.mdu_done_rd); end
                n_tests++; if (bus.stall_cnt !== 16'd4) begin n_fail++; $display("FAIL mdu_cnt got=%0d exp=4", bus.stall_cnt); end
            end
            $display("[TB] mdu c=%0d busy=%0b done=%0b stall=%0b", c, bus.mdu_busy, bus.mdu_done, bus.stall);
            tick();
        end
    endtask

    task automatic test_reset_mid_mdu();
        bit saw_done;
        do_reset();
        bus.id_mdu_start = 1'b1; bus.id_mdu_rd = 5'd9;
        tick();
        bus.id_mdu_start = 1'b0;
        tick();
        n_tests++; if (bus.mdu_busy !== 1'b1) begin n_fail++; $display("FAIL rmid_pre got=%0b exp=1", bus.mdu_busy); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (bus.mdu_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got=%0b exp=0", bus.mdu_busy); end
        tick();
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.mdu_done !== 1'b0 || bus.mdu_busy !== 1'b0) saw_done = 1'b1;
        end
        n_tests++; if (saw_done) begin n_fail++; $display("FAIL rmid_no_done got=1 exp=0"); end
        $display("[TB] test_reset_mid_mdu done");
    endtask

    task automatic test_saturation();
        do_reset();
        bus.ex_load = 1'b1; bus.ex_wen = 1'b1; bus.ex_rd = 5'd2;
        set_id_src(1, 2, 1);
        repeat (65534) tick();
        n_tests++; if (bus.stall_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL sat_pre got=%0h exp=fffe", bus.stall_cnt); end
        repeat (7) tick();
        n_tests++; if (bus.stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat got=%0h exp=ffff", bus.stall_cnt); end
        $display("[TB] test_saturation done");
    endtask

    task automatic test_random();
        int cyc, m_issue, m_cnt, e_ex, e_id;
        logic [AW-1:0] m_rd, s;
        bit e_stall, e_busy, e_done;
        do_reset();
        cyc = 0; m_issue = -1; m_cnt = 0; m_rd = '0;
        for (int t = 0; t < 600; t++) begin
            for (int k = 0; k < NUM_FWD; k++)
                set_prod(k, $urandom_range(0, 1), int'(rnd_reg()), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
            for (int r = 0; r < NUM_SRC; r++) begin
                set_ex_src(r, int'(rnd_reg()));
                set_id_src(r, int'(rnd_reg()), $urandom_range(0, 1));
            end
            bus.ex_wen = $urandom_range(0, 1); bus.ex_rd = rnd_reg(); bus.ex_load = ($urandom_range(0, 3) == 0);
            bus.id_branch = ($urandom_range(0, 2) == 0);
            bus.id_mdu_start = ($urandom_range(0, 4) == 0); bus.id_mdu_rd = rnd_reg();
            bus.flush = ($urandom_range(0, 9) == 0);
            #1;
            e_busy = (m_issue >= 0) && (cyc > m_issue) && (cyc <= m_issue + MDU_LAT);
            e_done = e_busy && (cyc == m_issue + MDU_LAT);
            e_stall = bus.id_mdu_start && e_busy;
            for (int r = 0; r < NUM_SRC; r++) begin
                s = bus.ex_src_reg[r*AW +: AW];
                e_ex = 0;
                for (int k = 0; k < NUM_FWD; k++) if (m_match(k, s)) begin e_ex = k + 1; break; end
                n_tests++; if (ex_sel(r) !== SW'(e_ex)) begin n_fail++; $display("FAIL rnd_ex t=%0d r=%0d got=%0d exp=%0d", t, r, ex_sel(r), e_ex); end
                s = bus.id_src_reg[r*AW +: AW];
                e_id = 0;
                if (bus.id_branch)
                    for (int k = 0; k < NUM_FWD; k++) begin
                        if (k == 0 && bus.prod_load[0]) continue;
                        if (m_match(k, s)) begin e_id = k + 1; break; end
                    end
                n_tests++; if (id_sel(r) !== SW'(e_id)) begin n_fail++; $display("FAIL rnd_id t=%0d r=%0d got=%0d exp=%0d", t, r, id_sel(r), e_id); end
                if (bus.id_src_used[r]) begin
                    if (bus.ex_load && bus.ex_wen && bus.ex_rd != 0 && bus.ex_rd == s) e_stall = 1;
                    if (bus.id_branch && bus.ex_wen && s != 0 && bus.ex_rd == s) e_stall = 1;
                    if (bus.id_branch && bus.prod_load[0] && m_match(0, s)) e_stall = 1;
                    if (e_busy && m_rd != 0 && m_rd == s) e_stall = 1;
                end
            end
            if (bus.flush) e_stall = 0;
            n_tests++; if (bus.stall !== e_stall) begin n_fail++; $display("FAIL rnd_stall t=%0d got=%0b exp=%0b", t, bus.stall, e_stall); end
            n_tests++; if (bus.mdu_busy !== e_busy) begin n_fail++; $display("FAIL rnd_busy t=%0d got=%0b exp=%0b", t, bus.mdu_busy, e_busy); end
            n_tests++; if (bus.mdu_done !== e_done) begin n_fail++; $display("FAIL rnd_done t=%0d got=%0b exp=%0b", t, bus.mdu_done, e_done); end
            if (e_busy) begin
                n_tests++; if (bus.mdu_done_rd !== m_rd) begin n_fail++; $display("FAIL rnd_done_rd t=%0d got=%0d exp=%0d", t, bus.mdu_done_rd, m_rd); end
            end
            n_tests++; if (bus.stall_cnt !== CNT_W'(m_cnt)) begin n_fail++; $display("FAIL rnd_cnt t=%0d got=%0d exp=%0d", t, bus.stall_cnt, m_cnt); end
            $display("[TB] rnd t=%0d stall=%0b busy=%0b done=%0b cnt=%0d", t, bus.stall, bus.mdu_busy, bus.mdu_done, bus.stall_cnt);
            if (e_stall) m_cnt++;
            if (bus.id_mdu_start && !e_stall && !bus.flush) begin m_issue = cyc; m_rd = bus.id_mdu_rd; end
            cyc++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_ex_fwd();
        test_load_use();
        test_branch();
        test_mdu();
        test_reset_mid_mdu();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the pipeline bypass logic. Generates operand-forward selects for N source ports in EX and for ID-stage branch compares across a configurable number of producer stages.
- Adds load-use and branch-use stall detection, plus a scoreboard for one long-latency multiply/divide (MDU) destination.
- Keeps a saturating stall-cycle counter for performance monitoring.
- Sits beside the ID/EX pipeline registers and drives the operand muxes and the ID/EX stall.

Parameters:
- NUM_SRC, 2, source operands per instruction.
- NUM_FWD, 2, forwarding producer stages; index 0 = EX/MEM (youngest), NUM_FWD-1 = MEM/WB (oldest).
- AW, 5, register-index width.
- LINK_REG, 31, register implicitly written by link instructions.
- MDU_LAT, 4, MDU cycles from issue to write-back, >=1.
- CNT_W, 16, stall-counter width.
- SW, $clog2(NUM_FWD+1), forward-select width (derived).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- prod_wen  in  NUM_FWD  producer k writes a register
- prod_rd  in  NUM_FWD*AW  producer k destination
- prod_link  in  NUM_FWD  producer k writes LINK_REG regardless of prod_rd
- prod_load  in  NUM_FWD  producer k is a load
- ex_wen  in  1  instruction in ID/EX writes a register
- ex_rd  in  AW  ID/EX destination
- ex_load  in  1  ID/EX instruction is a load
- ex_src_reg  in  NUM_SRC*AW  EX source registers
- ex_fwd_sel  out  NUM_SRC*SW  EX select; 0 = register file, k+1 = producer k
- id_src_reg  in  NUM_SRC*AW  ID source registers
- id_src_used  in  NUM_SRC  ID source actually read
- id_branch  in  1  ID instruction compares in ID
- id_fwd_sel  out  NUM_SRC*SW  ID select, same encoding; all 0 when !id_branch
- id_mdu_start  in  1  ID instruction is an MDU op
- id_mdu_rd  in  AW  MDU destination
- flush  in  1  squash ID instruction
- stall  out  1  hold PC and IF/ID; insert bubble into ID/EX
- mdu_busy  out  1  MDU operation outstanding
- mdu_done  out  1  one-cycle pulse; MDU result written this cycle
- mdu_done_rd  out  AW  destination for mdu_done
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Match rule for producer k against source r: prod_wen[k] and ((prod_rd[k]==r and r!=0) or (prod_link[k] and r==LINK_REG)).
- Forward selects are combinational.
  - ex_fwd_sel: the lowest matching index k gives k+1; no match gives 0.
  - id_fwd_sel: same rule, but producer 0 is skipped when prod_load[0]=1 (that case stalls instead).
- Stall is combinational and is the OR of:
  - (a) ex_load and ex_wen and ex_rd!=0 match any used ID source.
  - (b) id_branch and ex_wen match a used ID source, with the LINK_REG rule not applied to ID/EX.
  - (c) id_branch and prod_load[0] and producer 0 matches a used ID source.
  - (d) mdu_busy and busy_rd!=0 matches a used ID source.
  - (e) id_mdu_start and mdu_busy, a structural hazard.
  - Stall is forced to 0 when flush=1.
- MDU scoreboard state: busy, busy_rd, down-counter cnt.
  - Issue when id_mdu_start & !stall & !flush: busy<=1, busy_rd<=id_mdu_rd, cnt<=MDU_LAT-1.
  - While busy and cnt!=0: cnt decrements.
  - While busy and cnt==0: mdu_done=1 and mdu_done_rd=busy_rd for one cycle; busy<=0 next edge. The hazard in (d) still applies in that cycle.
  - Issue and completion in the same cycle is impossible because (e) stalls the issue.
  - flush does not cancel an outstanding MDU op.
  - mdu_busy=busy. mdu_done_rd holds busy_rd at all times.
- stall_cnt increments each cycle stall=1 and saturates at all-ones.
- Reset (async, rst_n=0): busy=0, busy_rd=0, cnt=0, stall_cnt=0, so mdu_busy=0 and mdu_done=0. Reset mid-operation abandons the MDU op without a done pulse.
- Combinational outputs during reset follow the inputs, using the reset state.

Decomposition:
- Shared package hazard_pkg holds:
  - AW and LINK_REG defaults;
  - forward-select encoding constants FWD_RF=0 and FWD_P(k)=k+1;
  - the producer struct {wen, rd, link, load}, so ports can later be packed.
- One sub-module fwd_match: priority match of one source against NUM_FWD producers, returning the select. It is instantiated 2*NUM_SRC times.

Test Plan:
- prod0={wen,rd=5}, prod1={wen,rd=5}, ex_src_reg[0]=5 -> ex_fwd_sel[0]=1 (youngest wins); rd=0 on both -> sel 0.
- prod0 link=1, rd=7; ex_src_reg[1]=31 -> sel[1]=1; id_branch=0 -> id_fwd_sel=0.
- ex_load=1, ex_rd=3, id_src_reg[0]=3 used -> stall=1 for one cycle, stall_cnt 0->1; same with id_src_used[0]=0 -> stall=0.
- id_branch, prod_load[0], prod_rd[0]=4 matches -> stall; next cycle load in prod1 -> stall=0, id_fwd_sel=2.
- MDU_LAT=4: issue rd=9 at cycle 0 -> mdu_busy cycles 1-4, mdu_done pulse at cycle 4 with rd=9; ID reading r9 stalls cycles 1-4; second id_mdu_start at cycle 2 stalls until cycle 5.
- rst_n low at cycle 2 of MDU op -> mdu_busy=0 immediately, no mdu_done; 2^16+5 stall cycles -> stall_cnt=0xFFFF.
